// File: rtl/jam_cost_loader.sv
// jam_cost_loader: streams a 64-entry cost table in for JAM, holds JAM in reset until loaded, captures its result.
// Define JAM_ROW_MIN_EN to add lb_out (sum of row minima) and flag results that beat the bound.
module jam_cost_loader (
    input  logic       CLK,
    input  logic       RST,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:0] in_data,
    input  logic       in_last,
    input  logic [2:0] W,
    input  logic [2:0] J,
    output logic [6:0] Cost,
    output logic       jam_rst,
    input  logic       Valid,
    input  logic [9:0] MinCost,
    input  logic [3:0] MatchCount,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [9:0] res_min,
    output logic [3:0] res_count,
    output logic [9:0] lb_out,
    output logic       err
);
    typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;
    state_t state, state_n;
    logic [6:0] tbl [64];
    logic [5:0] cnt;
    logic acc, lat, rel, bad_last, lb_bad;
    assign acc = (state == LOAD) && in_valid;
    assign lat = (state == RUN) && Valid;
    assign rel = (state == DONE) && res_ready;
    assign bad_last = acc && in_last && (cnt != 6'd63);
    assign Cost = tbl[{W, J}];
    always_ff @(posedge CLK) begin
        state <= RST ? LOAD : state_n;
    end
    always_comb begin
        state_n = (acc && cnt == 6'd63) ? RUN : lat ? DONE : rel ? LOAD : state;
    end
    always_comb begin
        in_ready = (state == LOAD);
    end
    always_ff @(posedge CLK) begin
        if (acc) tbl[cnt] <= in_data;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt       <= '0;
            jam_rst   <= 1'b1;
            res_valid <= 1'b0;
            res_min   <= '0;
            res_count <= '0;
            err       <= 1'b0;
        end else begin
            if (acc) cnt <= bad_last ? 6'd0 : cnt + 6'd1;
            jam_rst <= (state_n != RUN);
            res_valid <= lat ? 1'b1 : rel ? 1'b0 : res_valid;
            if (lat) begin
                res_min   <= MinCost;
                res_count <= MatchCount;
            end
            err <= err | bad_last | lb_bad;
        end
    end
`ifdef JAM_ROW_MIN_EN
    logic [6:0] row_min, cur_min;
    logic [9:0] lb_acc;
    // job 0 starts a fresh row, so the running minimum restarts from the incoming value
    assign cur_min = (cnt[2:0] == 3'd0 || in_data < row_min) ? in_data : row_min;
    assign lb_out = (state == LOAD) ? 10'd0 : lb_acc;
    assign lb_bad = lat && (MinCost < lb_acc);
    always_ff @(posedge CLK) begin
        if (RST) begin
            row_min <= 7'd127;
            lb_acc  <= '0;
        end else begin
            if (acc) row_min <= cur_min;
            if (bad_last || rel) lb_acc <= '0;
            else if (acc && cnt[2:0] == 3'd7) lb_acc <= lb_acc + {3'b000, cur_min};
        end
    end
`else
    assign lb_out = '0;
    assign lb_bad = 1'b0;
`endif
endmodule

// File: tb/tb_jam_cost_loader.sv
// tb_jam_cost_loader: directed vectors plus hand-written load/run/done sequences for jam_cost_loader.
module tb_jam_cost_loader;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [6:0] in_data = '0;
    logic       in_last = 1'b0;
    logic [2:0] W = '0;
    logic [2:0] J = '0;
    logic [6:0] Cost;
    logic       jam_rst;
    logic       Valid = 1'b0;
    logic [9:0] MinCost = '0;
    logic [3:0] MatchCount = '0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [9:0] res_min;
    logic [3:0] res_count;
    logic [9:0] lb_out;
    logic       err;
    int checks = 0;
    int errors = 0;

    jam_cost_loader dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .W(W), .J(J), .Cost(Cost), .jam_rst(jam_rst), .Valid(Valid),
        .MinCost(MinCost), .MatchCount(MatchCount), .res_valid(res_valid), .res_ready(res_ready),
        .res_min(res_min), .res_count(res_count), .lb_out(lb_out), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] w;
        logic [2:0] j;
        logic [6:0] cost;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [6:0] val(input int kind, input int k);
        case (kind)
            0: val = 7'd5;
            1: val = 7'(k);
            2: val = 7'd9;
            default: val = (k % 8 == 3) ? 7'(k / 8 + 1) : 7'(100 + k / 8);
        endcase
    endfunction

    task automatic load_n(input int start, input int n, input int kind, input int last_at);
        for (int k = start; k < start + n; k++) begin
            in_valid = 1'b1;
            in_data  = val(kind, k);
            in_last  = (k == last_at);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_valid(input logic [9:0] m, input logic [3:0] c);
        Valid = 1'b1;
        MinCost = m;
        MatchCount = c;
        tick();
        Valid = 1'b0;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        vec_t vecs [6];
        logic [9:0] exp_lb_ramp, exp_lb_rows;
        logic exp_err_rows;
`ifdef JAM_ROW_MIN_EN
        exp_lb_ramp = 10'd224;
        exp_lb_rows = 10'd36;
        exp_err_rows = 1'b1;
`else
        exp_lb_ramp = 10'd0;
        exp_lb_rows = 10'd0;
        exp_err_rows = 1'b0;
`endif
        vecs[0] = '{3'd3, 3'd6, 7'd30};
        vecs[1] = '{3'd7, 3'd7, 7'd63};
        vecs[2] = '{3'd0, 3'd0, 7'd0};
        vecs[3] = '{3'd0, 3'd7, 7'd7};
        vecs[4] = '{3'd5, 3'd2, 7'd42};
        vecs[5] = '{3'd7, 3'd0, 7'd56};

        tick();
        tick();
        RST = 1'b0;
        tick();
        chk("rst in_ready", in_ready, 1);
        chk("rst jam_rst", jam_rst, 1);
        chk("rst res_valid", res_valid, 0);
        chk("rst res_min", res_min, 0);
        chk("rst res_count", res_count, 0);
        chk("rst err", err, 0);
        chk("rst lb_out", lb_out, 0);

        // all-5 load with in_valid held high
        load_n(0, 63, 0, -1);
        chk("pre64 in_ready", in_ready, 1);
        chk("pre64 jam_rst", jam_rst, 1);
        in_valid = 1'b1;
        in_data = 7'd5;
        tick();
        chk("post64 in_ready", in_ready, 0);
        chk("post64 jam_rst", jam_rst, 0);
        in_data = 7'd77;
        tick();
        in_valid = 1'b0;
        chk("run hold in_ready", in_ready, 0);
        chk("run hold jam_rst", jam_rst, 0);
        for (int k = 0; k < 64; k++) begin
            {W, J} = 6'(k);
            #1;
            chk($sformatf("cost5 %0d", k), Cost, 5);
        end

        pulse_valid(10'd271, 4'd2);
        chk("latch res_valid", res_valid, 1);
        chk("latch res_min", res_min, 271);
        chk("latch res_count", res_count, 2);
        chk("latch jam_rst", jam_rst, 1);
`ifdef JAM_ROW_MIN_EN
        chk("all5 lb_out", lb_out, 40);
`else
        chk("all5 lb_out", lb_out, 0);
`endif
        for (int i = 0; i < 10; i++) begin
            if (i == 4) pulse_valid(10'd999, 4'd9);
            else tick();
        end
        chk("hold res_valid", res_valid, 1);
        chk("hold res_min", res_min, 271);
        chk("hold res_count", res_count, 2);
        chk("hold in_ready", in_ready, 0);
        handshake();
        chk("rel res_valid", res_valid, 0);
        chk("rel in_ready", in_ready, 1);
        chk("rel jam_rst", jam_rst, 1);
        chk("rel res_min kept", res_min, 271);
        chk("rel res_count kept", res_count, 2);
        chk("rel lb_out", lb_out, 0);
        chk("rel err", err, 0);

        // ramp load, table-driven lookups
        load_n(0, 64, 1, -1);
        chk("ramp jam_rst", jam_rst, 0);
        for (int i = 0; i < 6; i++) begin
            W = vecs[i].w;
            J = vecs[i].j;
            #1;
            chk($sformatf("ramp W%0d J%0d", vecs[i].w, vecs[i].j), Cost, vecs[i].cost);
        end
        chk("ramp lb_out", lb_out, exp_lb_ramp);
        pulse_valid(10'd500, 4'd1);
        chk("ramp res_min", res_min, 500);
        chk("ramp res_count", res_count, 1);
        chk("ramp err", err, 0);
        handshake();

        // framing error on 10th entry, then a full load
        load_n(0, 10, 2, 9);
        chk("frame err", err, 1);
        chk("frame in_ready", in_ready, 1);
        chk("frame jam_rst", jam_rst, 1);
        load_n(0, 63, 2, -1);
        chk("frame pre64 jam_rst", jam_rst, 1);
        load_n(63, 1, 2, -1);
        chk("frame post64 jam_rst", jam_rst, 0);
        chk("frame err sticky", err, 1);
        W = 3'd6;
        J = 3'd1;
        #1;
        chk("frame cost", Cost, 9);
        pulse_valid(10'd300, 4'd3);
        handshake();
        chk("frame err after done", err, 1);

        // reset during entry 40
        load_n(0, 40, 0, -1);
        in_valid = 1'b1;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        in_valid = 1'b0;
        chk("midrst err", err, 0);
        chk("midrst res_min", res_min, 0);
        chk("midrst jam_rst", jam_rst, 1);
        pulse_valid(10'd123, 4'd4);
        chk("load Valid res_valid", res_valid, 0);
        chk("load Valid res_min", res_min, 0);
        load_n(0, 63, 3, -1);
        chk("midrst pre64 jam_rst", jam_rst, 1);
        chk("midrst pre64 lb_out", lb_out, 0);
        load_n(63, 1, 3, -1);
        chk("midrst post64 jam_rst", jam_rst, 0);
        chk("rows lb_out", lb_out, exp_lb_rows);
        pulse_valid(10'd30, 4'd5);
        chk("rows res_min", res_min, 30);
        chk("rows res_count", res_count, 5);
        chk("rows err", err, exp_err_rows);
        handshake();
        chk("rows reload lb_out", lb_out, 0);
        chk("rows reload in_ready", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
